// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC redirect controller: FSM states, redirect source codes
// and the flush counter width.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_RUN       = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_IRQ_DRAIN = 3'd3,
    ST_IRQ_TAKE  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    SRC_NONE   = 3'd0,
    SRC_BOOT   = 3'd1,
    SRC_BRANCH = 3'd2,
    SRC_JUMP   = 3'd3,
    SRC_MRET   = 3'd4,
    SRC_IRQ    = 3'd5,
    SRC_RESUME = 3'd6
  } src_e;

  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/pc_redirect_stats.sv
// Saturating redirect / interrupt event counters; present only when
// PC_REDIRECT_STATS_EN is defined.
`ifdef PC_REDIRECT_STATS_EN
module pc_redirect_stats (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        redirect_inc_i,
  input  logic        irq_inc_i,
  output logic [31:0] redirect_count_o,
  output logic [31:0] irq_count_o
);

  logic [31:0] redirect_cnt_q;
  logic [31:0] irq_cnt_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      redirect_cnt_q <= '0;
      irq_cnt_q      <= '0;
    end else if (enable_i) begin
      if (redirect_inc_i && (redirect_cnt_q != '1)) redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (irq_inc_i && (irq_cnt_q != '1))           irq_cnt_q      <= irq_cnt_q + 32'd1;
    end
  end

  assign redirect_count_o = redirect_cnt_q;
  assign irq_count_o      = irq_cnt_q;

endmodule
`endif

// File: rtl/pc_redirect_ctrl.sv
// RV32I PC redirect sequencer: boot, branch/jump, mret and interrupt arbitration
// with pipeline drain and flush window. Optional stats: PC_REDIRECT_STATS_EN.
`ifndef size_X_LEN
`define size_X_LEN 32
`endif

module pc_redirect_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = `size_X_LEN
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            enable_design,
  input  logic [XLEN-1:0] boot_pc_i,
  input  logic [XLEN-1:0] next_pc_i,
  input  logic            branch_req_i,
  input  logic            jump_req_i,
  input  logic [XLEN-1:0] target_pc_i,
  input  logic            mret_req_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic            irq_pending_i,
  input  logic            irq_enable_i,
  input  logic [XLEN-1:0] interrupt_vector_i,
  input  logic            pipe_empty_i,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [2:0]      redirect_src_o,
  output logic            flush_o,
  output logic            stall_fetch_o,
  output logic            irq_ack_o,
  output logic [XLEN-1:0] irq_epc_o,
  output logic [2:0]      state_o
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]     redirect_count_o,
  output logic [31:0]     irq_count_o
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

  state_e                 state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic                   rv_q, rv_d;
  logic [XLEN-1:0]        rpc_q, rpc_d;
  src_e                   rsrc_q, rsrc_d;
  logic                   flush_q, flush_d;
  logic                   stall_q, stall_d;
  logic                   ack_q, ack_d;
  logic [XLEN-1:0]        epc_q, epc_d;

  // Redirect request built by the FSM; merged into the output regs below.
  logic                   go_redirect;
  logic [XLEN-1:0]        go_pc;
  src_e                   go_src;
  logic                   irq_live;

  assign irq_live = irq_pending_i & irq_enable_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rv_d        = 1'b0;
    rpc_d       = rpc_q;
    rsrc_d      = rsrc_q;
    flush_d     = flush_q;
    stall_d     = stall_q;
    ack_d       = 1'b0;
    epc_d       = epc_q;
    go_redirect = 1'b0;
    go_pc       = rpc_q;
    go_src      = rsrc_q;

    unique case (state_q)
      ST_BOOT: begin
        rv_d    = 1'b1;
        rpc_d   = boot_pc_i;
        rsrc_d  = SRC_BOOT;
        flush_d = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        flush_d = 1'b0;
        stall_d = 1'b0;
        if (mret_req_i) begin
          go_redirect = 1'b1;
          go_pc       = mepc_i;
          go_src      = SRC_MRET;
        end else if (branch_req_i || jump_req_i) begin
          go_redirect = 1'b1;
          go_pc       = target_pc_i;
          go_src      = jump_req_i ? SRC_JUMP : SRC_BRANCH;
        end else if (irq_live) begin
          epc_d   = next_pc_i;
          stall_d = 1'b1;
          state_d = ST_IRQ_DRAIN;
        end
      end
      ST_FLUSH: begin
        // Everything presented here is wrong-path and deliberately ignored.
        if (cnt_q <= 4'd1) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_IRQ_DRAIN: begin
        stall_d = 1'b1;
        // Older instructions still retiring move the return point.
        if (mret_req_i)                         epc_d = mepc_i;
        else if (branch_req_i || jump_req_i)    epc_d = target_pc_i;
        if (pipe_empty_i) begin
          if (irq_live) begin
            state_d = ST_IRQ_TAKE;
          end else begin
            go_redirect = 1'b1;
            go_pc       = epc_d;
            go_src      = SRC_RESUME;
          end
        end
      end
      ST_IRQ_TAKE: begin
        ack_d       = 1'b1;
        go_redirect = 1'b1;
        go_pc       = interrupt_vector_i;
        go_src      = SRC_IRQ;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase

    if (go_redirect) begin
      rv_d    = 1'b1;
      rpc_d   = go_pc;
      rsrc_d  = go_src;
      flush_d = 1'b1;
      stall_d = 1'b0;
      cnt_d   = FLUSH_LOAD;
      state_d = ST_FLUSH;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_BOOT;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
      rsrc_q  <= SRC_NONE;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      ack_q   <= 1'b0;
      epc_q   <= '0;
    end else if (!enable_design) begin
      // Frozen: only the one-cycle strobes are dropped.
      rv_q  <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      rsrc_q  <= rsrc_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      ack_q   <= ack_d;
      epc_q   <= epc_d;
    end
  end

  assign redirect_valid_o = rv_q;
  assign redirect_pc_o    = rpc_q;
  assign redirect_src_o   = rsrc_q;
  assign flush_o          = flush_q;
  assign stall_fetch_o    = stall_q;
  assign irq_ack_o        = ack_q;
  assign irq_epc_o        = epc_q;
  assign state_o          = state_q;

`ifdef PC_REDIRECT_STATS_EN
  pc_redirect_stats u_stats (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .enable_i         (enable_design),
    .redirect_inc_i   (rv_d && (rsrc_d != SRC_BOOT)),
    .irq_inc_i        (state_q == ST_IRQ_TAKE),
    .redirect_count_o (redirect_count_o),
    .irq_count_o      (irq_count_o)
  );
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: expected redirects are queued by the
// stimulus and checked by an independent monitor on redirect_valid_o / irq_ack_o.
module tb_pc_redirect_ctrl;

  localparam int XLEN         = 32;
  localparam int FLUSH_CYCLES = 2;

  localparam logic [2:0] S_BOOT = 3'd0, S_RUN = 3'd1, S_FLUSH = 3'd2, S_DRAIN = 3'd3;
  localparam logic [2:0] C_BOOT = 3'd1, C_BRANCH = 3'd2, C_JUMP = 3'd3, C_MRET = 3'd4,
                         C_IRQ = 3'd5, C_RESUME = 3'd6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            enable_design;
  logic [XLEN-1:0] boot_pc, next_pc, target_pc, mepc, vector;
  logic            branch_req, jump_req, mret_req, irq_pending, irq_enable, pipe_empty;
  logic            redirect_valid_o, flush_o, stall_fetch_o, irq_ack_o;
  logic [XLEN-1:0] redirect_pc_o, irq_epc_o;
  logic [2:0]      redirect_src_o, state_o;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0]     redirect_count_o, irq_count_o;
`endif

  // Expected redirect: {ack, src[2:0], pc[31:0]}
  logic [35:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  pc_redirect_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .XLEN(XLEN)) dut (
    .clk_i              (clk),
    .reset_i            (rst_n),
    .enable_design      (enable_design),
    .boot_pc_i          (boot_pc),
    .next_pc_i          (next_pc),
    .branch_req_i       (branch_req),
    .jump_req_i         (jump_req),
    .target_pc_i        (target_pc),
    .mret_req_i         (mret_req),
    .mepc_i             (mepc),
    .irq_pending_i      (irq_pending),
    .irq_enable_i       (irq_enable),
    .interrupt_vector_i (vector),
    .pipe_empty_i       (pipe_empty),
    .redirect_valid_o   (redirect_valid_o),
    .redirect_pc_o      (redirect_pc_o),
    .redirect_src_o     (redirect_src_o),
    .flush_o            (flush_o),
    .stall_fetch_o      (stall_fetch_o),
    .irq_ack_o          (irq_ack_o),
    .irq_epc_o          (irq_epc_o),
    .state_o            (state_o)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .redirect_count_o   (redirect_count_o),
    .irq_count_o        (irq_count_o)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic ack, input logic [2:0] src, input logic [31:0] pc);
    exp_q.push_back({ack, src, pc});
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (irq_ack_o) break;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(redirect_valid_o), 32'd0);
    check({tag, "_pc"},    redirect_pc_o,         32'd0);
    check({tag, "_src"},   32'(redirect_src_o),   32'd0);
    check({tag, "_flush"}, 32'(flush_o),          32'd0);
    check({tag, "_stall"}, 32'(stall_fetch_o),    32'd0);
    check({tag, "_ack"},   32'(irq_ack_o),        32'd0);
    check({tag, "_epc"},   irq_epc_o,             32'd0);
    check({tag, "_state"}, 32'(state_o),          32'(S_BOOT));
`ifdef PC_REDIRECT_STATS_EN
    check({tag, "_redirect_count"}, redirect_count_o, 32'd0);
    check({tag, "_irq_count"},      irq_count_o,      32'd0);
`endif
  endtask

  // Scoreboard monitor
  initial begin : monitor
    int          flush_run;
    logic [35:0] e;
    flush_run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        flush_run = 0;
      end else begin
        if (redirect_valid_o || irq_ack_o) begin
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_redirect: got pc 0x%0h src %0d ack %0b, expected none",
                     redirect_pc_o, redirect_src_o, irq_ack_o);
          end else begin
            e = exp_q.pop_front();
            check("redirect_valid", 32'(redirect_valid_o), 32'd1);
            check("redirect_pc",    redirect_pc_o,         e[31:0]);
            check("redirect_src",   32'(redirect_src_o),   32'(e[34:32]));
            check("irq_ack",        32'(irq_ack_o),        32'(e[35]));
            if (e[34:32] != C_BOOT) check("flush_in_redirect_cycle", 32'(flush_o), 32'd1);
          end
        end
        if (flush_o) begin
          flush_run++;
        end else if (flush_run > 0) begin
          check("flush_len", 32'(flush_run), 32'(FLUSH_CYCLES));
          flush_run = 0;
        end
      end
    end
  end

  // Stimulus
  initial begin : stimulus
    int n;
    rst_n = 1'b0; enable_design = 1'b0;
    boot_pc = '0; next_pc = '0; target_pc = '0; mepc = '0; vector = 32'h0000_0100;
    branch_req = 1'b0; jump_req = 1'b0; mret_req = 1'b0;
    irq_pending = 1'b0; irq_enable = 1'b0; pipe_empty = 1'b1;

    #12;
    check_reset_outputs("reset");
    step();
    rst_n = 1'b1;
    step();
    check("boot_hold_state", 32'(state_o), 32'(S_BOOT));

    // Boot
    boot_pc = 32'h0000_1000; enable_design = 1'b1;
    push_exp(1'b0, C_BOOT, 32'h0000_1000);
    step();
    check("boot_state_run", 32'(state_o), 32'(S_RUN));
    check("boot_no_flush",  32'(flush_o), 32'd0);

    // Branch; a jump during the flush is wrong-path
    branch_req = 1'b1; target_pc = 32'h0000_2040;
    push_exp(1'b0, C_BRANCH, 32'h0000_2040);
    step();
    check("branch_state_flush", 32'(state_o), 32'(S_FLUSH));
    branch_req = 1'b0; jump_req = 1'b1; target_pc = 32'h0000_5555;
    step();
    step();
    jump_req = 1'b0;
    check("branch_back_to_run", 32'(state_o), 32'(S_RUN));

    // Frozen while disabled, then branch+jump together reports JUMP
    enable_design = 1'b0; branch_req = 1'b1; jump_req = 1'b1; target_pc = 32'h0000_6000;
    repeat (3) step();
    check("disabled_hold_state", 32'(state_o), 32'(S_RUN));
    enable_design = 1'b1;
    push_exp(1'b0, C_JUMP, 32'h0000_6000);
    step();
    branch_req = 1'b0; jump_req = 1'b0;
    check("jump_state_flush", 32'(state_o), 32'(S_FLUSH));
    step();
    step();
    check("jump_back_to_run", 32'(state_o), 32'(S_RUN));

    // mret + branch + irq together: mret only, irq after the flush
    mret_req = 1'b1; mepc = 32'h0000_3000; branch_req = 1'b1; target_pc = 32'h0000_4444;
    irq_pending = 1'b1; irq_enable = 1'b1; next_pc = 32'h0000_3000; pipe_empty = 1'b1;
    push_exp(1'b0, C_MRET, 32'h0000_3000);
    push_exp(1'b1, C_IRQ,  32'h0000_0100);
    step();
    mret_req = 1'b0; branch_req = 1'b0;
    check("mret_state_flush", 32'(state_o), 32'(S_FLUSH));
    wait_ack(n);
    check("mret_then_irq_latency", 32'(n), 32'd5);
    check("mret_irq_epc", irq_epc_o, 32'h0000_3000);
    irq_pending = 1'b0; irq_enable = 1'b0;
    step();
    step();
    check("irq1_back_to_run", 32'(state_o), 32'(S_RUN));

    // Interrupt with a branch in flight while draining
    irq_pending = 1'b1; irq_enable = 1'b1; next_pc = 32'h0000_1100; pipe_empty = 1'b0;
    push_exp(1'b1, C_IRQ, 32'h0000_0100);
    step();
    check("drain_state",     32'(state_o),       32'(S_DRAIN));
    check("drain_stall",     32'(stall_fetch_o), 32'd1);
    check("drain_epc_nextpc", irq_epc_o,         32'h0000_1100);
    branch_req = 1'b1; target_pc = 32'h0000_1800;
    step();
    branch_req = 1'b0;
    check("drain_epc_branch", irq_epc_o, 32'h0000_1800);
    begin
      int stall_cycles;
      stall_cycles = (stall_fetch_o && state_o == S_DRAIN) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
        step();
        if (stall_fetch_o && state_o == S_DRAIN) stall_cycles++;
      end
      check("drain_stall_cycles", 32'(stall_cycles), 32'd4);
    end
    pipe_empty = 1'b1;
    wait_ack(n);
    check("drain_irq_latency", 32'(n), 32'd2);
    check("drain_irq_epc", irq_epc_o, 32'h0000_1800);
    irq_pending = 1'b0; irq_enable = 1'b0;
    step();
    step();
    check("irq2_back_to_run", 32'(state_o), 32'(S_RUN));

    // Interrupt withdrawn during drain: resume at the saved PC
    irq_pending = 1'b1; irq_enable = 1'b1; next_pc = 32'h0000_1100; pipe_empty = 1'b0;
    step();
    check("resume_drain_epc", irq_epc_o, 32'h0000_1100);
    irq_pending = 1'b0;
    step();
    step();
    check("resume_waiting_state", 32'(state_o), 32'(S_DRAIN));
    check("resume_waiting_stall", 32'(stall_fetch_o), 32'd1);
    pipe_empty = 1'b1;
    push_exp(1'b0, C_RESUME, 32'h0000_1100);
    step();
    check("resume_state_flush", 32'(state_o), 32'(S_FLUSH));
    step();
    step();
    check("resume_back_to_run", 32'(state_o), 32'(S_RUN));
    irq_enable = 1'b0;
`ifdef PC_REDIRECT_STATS_EN
    check("stats_redirect_count", redirect_count_o, 32'd6);
    check("stats_irq_count",      irq_count_o,      32'd2);
`endif

    // Asynchronous reset in the middle of a drain
    irq_pending = 1'b1; irq_enable = 1'b1; next_pc = 32'h0000_2222; pipe_empty = 1'b0;
    step();
    check("rst_drain_state", 32'(state_o), 32'(S_DRAIN));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_drain_reset");
    irq_pending = 1'b0; irq_enable = 1'b0; pipe_empty = 1'b1;
    step();
    rst_n = 1'b1; boot_pc = 32'h0000_1040;
    push_exp(1'b0, C_BOOT, 32'h0000_1040);
    step();
    check("reboot_state_run", 32'(state_o), 32'(S_RUN));
    repeat (4) step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
